// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: multi-cycle fetch/decode/exec/mem control for the reg_alu datapath; psr bits are {Z,L,N,F,C} (Z=bit4, C=bit0)
module cpu_ctrl_fsm (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] instr,
    input  logic [4:0]  psr_in,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_en,
    output logic        pc_en,
    output logic        reg_write,
    output logic [3:0]  rSrc,
    output logic [3:0]  rDst,
    output logic [7:0]  imm,
    output logic [3:0]  aluOp,
    output logic        IMM_MUX,
    output logic [1:0]  WB_MUX,
    output logic        WB_MUX0,
    output logic        COND_RSLT,
    output logic [4:0]  psr,
    output logic        halt
);
    localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_CMP = 4'd2, ALU_AND = 4'd3,
                           ALU_OR = 4'd4, ALU_XOR = 4'd5, ALU_MOV = 4'd6, ALU_LUI = 4'd7,
                           ALU_SLL = 4'd8, ALU_SRL = 4'd9, ALU_SLA = 4'd10, ALU_SRA = 4'd11;
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, HALT} state_t;
    state_t state, state_nx;
    logic [15:0] ir;
    logic [3:0] op, ext, alu_code;
    logic [4:0] rr, im, sh;
    logic is_rr, is_imm, is_sh, is_alu, is_load, is_stor, is_scond, is_cmp, is_flag, legal, cond;
    // register-register ext codes and immediate opcodes share one encoding
    function automatic logic [4:0] rr_map(input logic [3:0] k);
        case (k)
            4'h5: rr_map = {1'b1, ALU_ADD};
            4'h9: rr_map = {1'b1, ALU_SUB};
            4'hB: rr_map = {1'b1, ALU_CMP};
            4'h1: rr_map = {1'b1, ALU_AND};
            4'h2: rr_map = {1'b1, ALU_OR};
            4'h3: rr_map = {1'b1, ALU_XOR};
            4'hD: rr_map = {1'b1, ALU_MOV};
            default: rr_map = 5'd0;
        endcase
    endfunction
    function automatic logic [4:0] sh_map(input logic [3:0] k);
        case (k)
            4'h4: sh_map = {1'b1, ALU_SLL};
            4'h0: sh_map = {1'b1, ALU_SRL};
            4'h5: sh_map = {1'b1, ALU_SLA};
            4'h1: sh_map = {1'b1, ALU_SRA};
            default: sh_map = 5'd0;
        endcase
    endfunction
    // instruction decode from the latched IR
    always_comb begin
        op       = ir[15:12];
        ext      = ir[7:4];
        rr       = rr_map(ext);
        im       = rr_map(op);
        sh       = sh_map(ext);
        is_rr    = (op == 4'h0) && rr[4];
        is_imm   = (op == 4'hF) || im[4];
        is_sh    = (op == 4'h8) && sh[4];
        is_load  = (op == 4'h4) && (ext == 4'h0);
        is_stor  = (op == 4'h4) && (ext == 4'h4);
        is_scond = (op == 4'h4) && (ext == 4'hD);
        is_alu   = is_rr || is_imm || is_sh;
        alu_code = is_rr ? rr[3:0] : is_imm ? (op == 4'hF ? ALU_LUI : im[3:0]) : is_sh ? sh[3:0] : ALU_ADD;
        is_cmp   = is_alu && (alu_code == ALU_CMP);
        is_flag  = is_alu && (alu_code == ALU_ADD || alu_code == ALU_SUB || alu_code == ALU_CMP);
        legal    = is_alu || is_load || is_stor || is_scond;
        case (ir[3:0])
            4'h0: cond = psr[4];
            4'h1: cond = !psr[4];
            4'h2: cond = psr[0];
            4'h3: cond = !psr[0];
            4'h6: cond = psr[2];
            4'h7: cond = !psr[2];
            4'h8: cond = psr[1];
            4'h9: cond = !psr[1];
            default: cond = 1'b0;
        endcase
    end
    assign rSrc      = ir[3:0];
    assign rDst      = ir[11:8];
    assign imm       = ir[7:0];
    assign aluOp     = alu_code;
    assign IMM_MUX   = is_imm;
    assign WB_MUX    = is_load ? 2'b11 : is_alu ? 2'b10 : is_scond ? 2'b01 : 2'b00;
    assign WB_MUX0   = 1'b0;
    assign COND_RSLT = is_scond && cond;
    // next state and strobes; reset gates every enable so an in-flight access drops immediately
    always_comb begin
        state_nx  = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = 1'b0;
        ir_en     = 1'b0;
        pc_en     = 1'b0;
        reg_write = 1'b0;
        halt      = 1'b0;
        case (state)
            FETCH: begin
                mem_req  = 1'b1;
                ir_en    = mem_ack;
                state_nx = mem_ack ? DECODE : FETCH;
            end
            DECODE: state_nx = legal ? EXEC : HALT;
            EXEC: begin
                reg_write = !(is_load || is_stor) && !is_cmp;
                pc_en     = !(is_load || is_stor);
                state_nx  = (is_load || is_stor) ? MEM : FETCH;
            end
            MEM: begin
                mem_req   = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = is_stor;
                reg_write = mem_ack && is_load;
                pc_en     = mem_ack;
                state_nx  = mem_ack ? FETCH : MEM;
            end
            HALT: halt = 1'b1;
            default: state_nx = FETCH;
        endcase
        if (!reset_n) begin
            mem_req   = 1'b0;
            mem_we    = 1'b0;
            addr_sel  = 1'b0;
            ir_en     = 1'b0;
            pc_en     = 1'b0;
            reg_write = 1'b0;
            halt      = 1'b0;
        end
    end
    // state, IR and PSR registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= FETCH;
            ir    <= 16'd0;
            psr   <= 5'd0;
        end else begin
            state <= state_nx;
            if (ir_en) ir <= instr;
            if (state == EXEC && is_flag) psr <= psr_in;
        end
    end
endmodule
